// File: rtl/mdu_pkg.sv
// Shared encodings, FSM state type and sizing helpers for the multiply/divide unit.
package mdu_pkg;

    localparam logic [2:0] MDU_MULT  = 3'd0;
    localparam logic [2:0] MDU_MULTU = 3'd1;
    localparam logic [2:0] MDU_DIV   = 3'd2;
    localparam logic [2:0] MDU_DIVU  = 3'd3;
    localparam logic [2:0] MDU_MTHI  = 3'd4;
    localparam logic [2:0] MDU_MTLO  = 3'd5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } mduState_t;

    // Counter must be able to hold WIDTH itself, not just WIDTH-1.
    function automatic int cntWidth(input int width);
        return $clog2(width + 1);
    endfunction

    function automatic logic isMulDiv(input logic [2:0] op);
        return op <= MDU_DIVU;
    endfunction

    function automatic logic isDivOp(input logic [2:0] op);
        return (op == MDU_DIV) || (op == MDU_DIVU);
    endfunction

endpackage

// File: rtl/mdu_iter.sv
// Unsigned iterative datapath: radix-2 shift-add multiply and restoring divide
// sharing one {hi, lo} accumulator pair. Signs are handled by the caller.
module mdu_iter
    import mdu_pkg::*;
#(
    parameter int WIDTH      = 32,
    parameter int MUL_SINGLE = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             loadDiv,
    input  logic             step,
    input  logic             stepDiv,
    input  logic [WIDTH-1:0] opA,
    input  logic [WIDTH-1:0] opB,
    output logic [WIDTH-1:0] accHi,
    output logic [WIDTH-1:0] accLo
);

    logic [WIDTH-1:0]   accHiReg;
    logic [WIDTH-1:0]   accLoReg;
    logic [WIDTH-1:0]   operandReg;
    logic [2*WIDTH-1:0] fullProd;
    logic [WIDTH:0]     addSum;
    logic [WIDTH:0]     divShift;
    logic [WIDTH-1:0]   divDiff;
    logic               divFits;

    generate
        if (MUL_SINGLE != 0) begin : gen_mul_single
            assign fullProd = {{WIDTH{1'b0}}, opA} * {{WIDTH{1'b0}}, opB};
        end else begin : gen_mul_iter
            assign fullProd = '0;
        end
    endgenerate

    // The subtraction only needs WIDTH bits: its result is kept only when it
    // is smaller than the divisor.
    always_comb begin
        addSum   = {1'b0, accHiReg} + (accLoReg[0] ? {1'b0, operandReg} : {(WIDTH+1){1'b0}});
        divShift = {accHiReg, accLoReg[WIDTH-1]};
        divDiff  = divShift[WIDTH-1:0] - operandReg;
        divFits  = divShift >= {1'b0, operandReg};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            accHiReg   <= '0;
            accLoReg   <= '0;
            operandReg <= '0;
        end else if (load) begin
            if (!loadDiv && (MUL_SINGLE != 0)) begin
                {accHiReg, accLoReg} <= fullProd;
                operandReg           <= opA;
            end else if (loadDiv) begin
                accHiReg   <= '0;
                accLoReg   <= opA;
                operandReg <= opB;
            end else begin
                accHiReg   <= '0;
                accLoReg   <= opB;
                operandReg <= opA;
            end
        end else if (step) begin
            if (stepDiv) begin
                accHiReg <= divFits ? divDiff : divShift[WIDTH-1:0];
                accLoReg <= {accLoReg[WIDTH-2:0], divFits};
            end else begin
                accHiReg <= addSum[WIDTH:1];
                accLoReg <= {addSum[0], accLoReg[WIDTH-1:1]};
            end
        end
    end

    assign accHi = accHiReg;
    assign accLo = accLoReg;

endmodule

// File: rtl/mdu_hilo.sv
// Execute-stage multiply/divide unit: FSM, sign handling, stall request and
// the architectural HI/LO registers.
module mdu_hilo
    import mdu_pkg::*;
#(
    parameter int WIDTH      = 32,
    parameter int MUL_SINGLE = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    input  logic [2:0]       op_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             flush_i,
    input  logic             hold_i,
    output logic             stall_o,
    output logic             busy_o,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o
);

    localparam int CW = cntWidth(WIDTH);

    mduState_t          stateReg;
    logic [CW-1:0]      cntReg;
    logic [WIDTH-1:0]   hiReg;
    logic [WIDTH-1:0]   loReg;
    logic [WIDTH-1:0]   aRawReg;
    logic               busyReg;
    logic               divReg;
    logic               negResReg;
    logic               negRemReg;
    logic               divZeroReg;

    logic               accept;
    logic               opSigned;
    logic               negA;
    logic               negB;
    logic [WIDTH-1:0]   magA;
    logic [WIDTH-1:0]   magB;
    logic [WIDTH-1:0]   iterHi;
    logic [WIDTH-1:0]   iterLo;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   quot;
    logic [WIDTH-1:0]   rem;
    logic [WIDTH-1:0]   hiRes;
    logic [WIDTH-1:0]   loRes;

    always_comb begin
        accept   = (stateReg == IDLE) && start_i && isMulDiv(op_i) && !flush_i;
        opSigned = (op_i == MDU_MULT) || (op_i == MDU_DIV);
        negA     = opSigned && a_i[WIDTH-1];
        negB     = opSigned && b_i[WIDTH-1];
        magA     = negA ? -a_i : a_i;
        magB     = negB ? -b_i : b_i;
    end

    mdu_iter #(
        .WIDTH      (WIDTH),
        .MUL_SINGLE (MUL_SINGLE)
    ) u_iter (
        .clk     (clk),
        .rst     (rst),
        .load    (accept),
        .loadDiv (isDivOp(op_i)),
        .step    (stateReg == CALC),
        .stepDiv (divReg),
        .opA     (magA),
        .opB     (magB),
        .accHi   (iterHi),
        .accLo   (iterLo)
    );

    // Most-negative / -1 needs no special case: the magnitude quotient is
    // 100..0 and negating it gives the same pattern back.
    always_comb begin
        prod  = {iterHi, iterLo};
        if (negResReg) begin
            prod = -prod;
        end
        quot  = negResReg ? -iterLo : iterLo;
        rem   = negRemReg ? -iterHi : iterHi;
        hiRes = prod[2*WIDTH-1:WIDTH];
        loRes = prod[WIDTH-1:0];
        if (divReg) begin
            if (divZeroReg) begin
                hiRes = aRawReg;
                loRes = '1;
            end else begin
                hiRes = rem;
                loRes = quot;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stateReg   <= IDLE;
            cntReg     <= '0;
            hiReg      <= '0;
            loReg      <= '0;
            aRawReg    <= '0;
            busyReg    <= 1'b0;
            divReg     <= 1'b0;
            negResReg  <= 1'b0;
            negRemReg  <= 1'b0;
            divZeroReg <= 1'b0;
        end else if (flush_i) begin
            stateReg <= IDLE;
            cntReg   <= '0;
            busyReg  <= 1'b0;
        end else begin
            case (stateReg)
                IDLE: begin
                    if (accept) begin
                        divReg     <= isDivOp(op_i);
                        negResReg  <= negA ^ negB;
                        negRemReg  <= negA;
                        divZeroReg <= (b_i == '0);
                        aRawReg    <= a_i;
                        busyReg    <= 1'b1;
                        if ((MUL_SINGLE != 0) && !isDivOp(op_i)) begin
                            stateReg <= DONE;
                            cntReg   <= '0;
                        end else begin
                            stateReg <= CALC;
                            cntReg   <= CW'(WIDTH);
                        end
                    end else if (start_i && !hold_i) begin
                        if (op_i == MDU_MTHI) begin
                            hiReg <= a_i;
                        end
                        if (op_i == MDU_MTLO) begin
                            loReg <= a_i;
                        end
                    end
                end
                CALC: begin
                    cntReg <= cntReg - 1'b1;
                    if (cntReg == CW'(1)) begin
                        stateReg <= DONE;
                    end
                end
                DONE: begin
                    if (!hold_i) begin
                        hiReg    <= hiRes;
                        loReg    <= loRes;
                        busyReg  <= 1'b0;
                        stateReg <= IDLE;
                    end
                end
                default: stateReg <= IDLE;
            endcase
        end
    end

    assign stall_o = accept || (stateReg == CALC);
    assign busy_o  = busyReg;
    assign hi_o    = hiReg;
    assign lo_o    = loReg;

endmodule

// File: tb/tb_mdu_hilo.sv
// Randomised bench for mdu_hilo: an iterative instance and a single-cycle
// multiply instance, both checked against an arithmetic HI/LO model.
module tb_mdu_hilo;

    localparam int W = 32;

    logic clk = 1'b0;
    logic rst;

    logic [1:0]          startS, flushS, holdS;
    logic [1:0][2:0]     opS;
    logic [1:0][W-1:0]   aS, bS;
    wire  [1:0]          stallS, busyS;
    wire  [1:0][W-1:0]   hiS, loS;
    logic [1:0][W-1:0]   mHi, mLo;

    int nChecks = 0;
    int nPass   = 0;

    always #5 clk = ~clk;

    mdu_hilo #(.WIDTH(W), .MUL_SINGLE(0)) dutIter (
        .clk(clk), .rst(rst), .start_i(startS[0]), .op_i(opS[0]),
        .a_i(aS[0]), .b_i(bS[0]), .flush_i(flushS[0]), .hold_i(holdS[0]),
        .stall_o(stallS[0]), .busy_o(busyS[0]), .hi_o(hiS[0]), .lo_o(loS[0])
    );

    mdu_hilo #(.WIDTH(W), .MUL_SINGLE(1)) dutSingle (
        .clk(clk), .rst(rst), .start_i(startS[1]), .op_i(opS[1]),
        .a_i(aS[1]), .b_i(bS[1]), .flush_i(flushS[1]), .hold_i(holdS[1]),
        .stall_o(stallS[1]), .busy_o(busyS[1]), .hi_o(hiS[1]), .lo_o(loS[1])
    );

    task automatic checkVal(input string tag, input logic [63:0] got, input logic [63:0] exp);
        nChecks++;
        if (got === exp) nPass++;
        else $display("FAIL %s: got %h, expected %h", tag, got, exp);
    endtask

    // Architectural result {HI, LO} computed with plain integer arithmetic.
    function automatic logic [63:0] refOp(input logic [2:0] op, input logic [W-1:0] a, b,
                                          input logic [W-1:0] curHi, curLo);
        longint sa, sb, p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (op)
            3'd0: begin p = sa * sb; return p; end
            3'd1: return {32'b0, a} * {32'b0, b};
            3'd2: begin
                if (b == 0) return {a, 32'hFFFF_FFFF};
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'h0, 32'h8000_0000};
                return {32'(sa % sb), 32'(sa / sb)};
            end
            3'd3: begin
                if (b == 0) return {a, 32'hFFFF_FFFF};
                return {a % b, a / b};
            end
            3'd4: return {a, curLo};
            3'd5: return {curHi, a};
            default: return {curHi, curLo};
        endcase
    endfunction

    // Issues one instruction and keeps it presented while the unit stalls,
    // as the held E stage would.
    task automatic runOp(input int d, input logic [2:0] op, input logic [W-1:0] a, b,
                         input int expStall);
        logic [63:0] expv;
        int stalls;
        expv = refOp(op, a, b, mHi[d], mLo[d]);
        startS[d] = 1'b1; opS[d] = op; aS[d] = a; bS[d] = b;
        stalls = 0;
        #1;
        while (stallS[d] && stalls < 100) begin
            stalls++;
            @(negedge clk); #1;
        end
        checkVal("stall_cycles", 64'(stalls), 64'(expStall));
        if (expStall != 0) checkVal("busy_in_done", busyS[d], 1'b1);
        @(negedge clk);
        startS[d] = 1'b0;
        #1;
        checkVal("busy_after", busyS[d], 1'b0);
        checkVal("hi", hiS[d], expv[63:32]);
        checkVal("lo", loS[d], expv[31:0]);
        mHi[d] = expv[63:32];
        mLo[d] = expv[31:0];
        $display("dut%0d op=%0d a=%h b=%h stalls=%0d hi=%h lo=%h", d, op, a, b, stalls, hiS[d], loS[d]);
    endtask

    initial begin
        logic [2:0] op;
        logic [W-1:0] a, b;
        int r;

        rst = 1'b1;
        startS = '0; flushS = '0; holdS = '0; opS = '0; aS = '0; bS = '0;
        mHi = '0; mLo = '0;
        repeat (2) @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            checkVal("rst_hi", hiS[d], 0);
            checkVal("rst_lo", loS[d], 0);
            checkVal("rst_busy", busyS[d], 0);
            checkVal("rst_stall", stallS[d], 0);
        end
        rst = 1'b0;
        @(negedge clk);

        // Directed cases with known answers.
        runOp(0, 3'd0, 32'hFFFF_FFFD, 32'd5, 33);
        checkVal("plan_mult_hi", hiS[0], 32'hFFFF_FFFF);
        checkVal("plan_mult_lo", loS[0], 32'hFFFF_FFF1);
        runOp(0, 3'd2, 32'd7, 32'hFFFF_FFFE, 33);
        checkVal("plan_div_lo", loS[0], 32'hFFFF_FFFD);
        checkVal("plan_div_hi", hiS[0], 32'h0000_0001);
        runOp(0, 3'd3, 32'hFFFF_FFFF, 32'h10, 33);
        checkVal("plan_divu_lo", loS[0], 32'h0FFF_FFFF);
        checkVal("plan_divu_hi", hiS[0], 32'h0000_000F);
        runOp(0, 3'd2, 32'd5, 32'd0, 33);
        checkVal("plan_div0_hi", hiS[0], 32'd5);
        checkVal("plan_div0_lo", loS[0], 32'hFFFF_FFFF);
        runOp(0, 3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 33);

        // Flush at the 10th CALC cycle leaves HI/LO untouched.
        runOp(0, 3'd4, 32'h1234, 32'd0, 0);
        runOp(0, 3'd5, 32'h5678, 32'd0, 0);
        startS[0] = 1'b1; opS[0] = 3'd3; aS[0] = 32'hCAFE_F00D; bS[0] = 32'd3;
        repeat (10) @(negedge clk);
        checkVal("flush_stall_before", stallS[0], 1'b1);
        flushS[0] = 1'b1; startS[0] = 1'b0;
        @(negedge clk);
        flushS[0] = 1'b0;
        #1;
        checkVal("flush_stall_after", stallS[0], 1'b0);
        checkVal("flush_busy", busyS[0], 1'b0);
        repeat (3) @(negedge clk);
        checkVal("flush_hi", hiS[0], 32'h1234);
        checkVal("flush_lo", loS[0], 32'h5678);
        $display("dut0 flushed divu, hi=%h lo=%h", hiS[0], loS[0]);

        // hold_i for three cycles in DONE with start_i still asserted.
        startS[0] = 1'b1; opS[0] = 3'd2; aS[0] = 32'd100; bS[0] = 32'hFFFF_FFF9;
        r = 0;
        #1;
        while (stallS[0] && r < 100) begin r++; @(negedge clk); #1; end
        checkVal("hold_stall_cycles", 64'(r), 64'd33);
        holdS[0] = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); #1;
            checkVal("hold_busy", busyS[0], 1'b1);
            checkVal("hold_stall", stallS[0], 1'b0);
            checkVal("hold_hi", hiS[0], 32'h1234);
            checkVal("hold_lo", loS[0], 32'h5678);
        end
        holdS[0] = 1'b0;
        @(negedge clk);
        startS[0] = 1'b0;
        #1;
        mHi[0] = 32'd2; mLo[0] = 32'hFFFF_FFF2;
        checkVal("hold_done_hi", hiS[0], mHi[0]);
        checkVal("hold_done_lo", loS[0], mLo[0]);
        checkVal("hold_no_restart", busyS[0], 1'b0);
        $display("dut0 held div, hi=%h lo=%h", hiS[0], loS[0]);
        startS[0] = 1'b1; opS[0] = 3'd4; aS[0] = 32'hDEAD_BEEF; holdS[0] = 1'b1;
        @(negedge clk);
        startS[0] = 1'b0; holdS[0] = 1'b0;
        #1;
        checkVal("mthi_held", hiS[0], mHi[0]);

        // Random traffic on the iterative unit.
        for (int i = 0; i < 24; i++) begin
            op = 3'($urandom_range(0, 5));
            a  = $urandom;
            r  = $urandom_range(0, 7);
            b  = (r == 0) ? 32'd0 : (r == 2) ? 32'($urandom_range(1, 20)) : $urandom;
            if (r == 1) begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
            if (r == 3) a = -a;
            runOp(0, op, a, b, (op <= 3'd3) ? 33 : 0);
        end

        // Single-cycle multiply instance.
        runOp(1, 3'd1, 32'hFFFF_FFFF, 32'd2, 1);
        checkVal("plan_multu_hi", hiS[1], 32'h0000_0001);
        checkVal("plan_multu_lo", loS[1], 32'hFFFF_FFFE);
        for (int i = 0; i < 8; i++) begin
            op = 3'($urandom_range(0, 3));
            runOp(1, op, $urandom, $urandom, (op <= 3'd1) ? 1 : 33);
        end

        // Reset in the middle of CALC clears everything immediately.
        runOp(0, 3'd4, 32'hAAAA_5555, 32'd0, 0);
        startS[0] = 1'b1; opS[0] = 3'd0; aS[0] = 32'd9; bS[0] = 32'd9;
        repeat (5) @(negedge clk);
        checkVal("pre_rst_busy", busyS[0], 1'b1);
        rst = 1'b1;
        #1;
        checkVal("midrst_hi", hiS[0], 0);
        checkVal("midrst_lo", loS[0], 0);
        checkVal("midrst_busy", busyS[0], 0);
        @(negedge clk);
        rst = 1'b0; startS[0] = 1'b0;
        mHi = '0; mLo = '0;
        @(negedge clk); #1;
        checkVal("post_rst_stall", stallS[0], 0);
        checkVal("post_rst_hi", hiS[0], 0);
        runOp(0, 3'd3, 32'd1000, 32'd7, 33);

        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule

// File: doc/mdu_hilo.md
# mdu_hilo

Parametrised multiply/divide unit with architectural HI/LO registers for the MIPS pipeline. It sits in the execute stage beside the ALU. It executes MULT/MULTU/DIV/DIVU iteratively and MTHI/MTLO in one cycle, and raises a stall request that freezes the front of the pipeline while an operation is in flight. It generalises the current single-cycle HI/LO write path in three ways: configurable data width, a selectable multiply mode, and flush/hold handling.

## Interface
- WIDTH, 32, operand, HI and LO width; must be ≥ 4.
- MUL_SINGLE, 0, multiply implementation:
  - 1: single-cycle combinational multiply.
  - 0: radix-2 shift-add, WIDTH iterations.
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- start_i  in  1  E-stage instruction is an MDU op (qualifies op_i).
- op_i  in  3  operation: MULT=0, MULTU=1, DIV=2, DIVU=3, MTHI=4, MTLO=5; other codes are no-ops.
- a_i, b_i  in  WIDTH  rs/rt operands, already forwarded. Dividend is a_i, divisor is b_i.
- flush_i  in  1  E-stage flush; kills the in-flight op.
- hold_i  in  1  E stage held by another stall source.
- stall_o  out  1  stall request to hazard unit; combinational.
- busy_o  out  1  registered; state is not IDLE.
- hi_o, lo_o  out  WIDTH  architectural HI and LO, registered.

## Operation
- Reset values:
  - hi_o = 0, lo_o = 0, busy_o = 0.
  - State = IDLE; counter = 0.
  - stall_o = 0 whenever start_i = 0.
- States:
  - IDLE: the only state in which start_i is accepted.
  - CALC: iterating.
  - DONE: result ready; HI/LO are written from this state.
- IDLE with start_i, a mult/div op, and no flush_i:
  - Latch |a|, |b| and the result signs. Signed ops use the two's-complement magnitude; unsigned ops take operands as-is.
  - Next state is CALC with counter = WIDTH.
  - Exception: MUL_SINGLE=1 and op is MULT/MULTU goes directly to DONE.
- CALC performs one iteration per cycle and decrements the counter. At counter = 1 the next state is DONE.
  - Multiply: shift-add into a 2·WIDTH accumulator.
  - Divide: restoring shift-subtract, producing quotient and remainder.
- DONE:
  - Apply sign fix: product negated if sign(a)^sign(b); quotient negated if sign(a)^sign(b); remainder takes sign(a).
  - If hold_i = 0: write HI = upper half / remainder, LO = lower half / quotient, then go to IDLE.
  - If hold_i = 1: stay in DONE and do not write.
- start_i is ignored in CALC and DONE, because the same held instruction is still presenting it.
- Divide by zero (b_i = 0, signed or unsigned): HI = a_i, LO = all ones. Takes the normal cycle count.
- Signed overflow (most-negative / −1): LO = most-negative, HI = 0. No trap is raised.
- MTHI/MTLO:
  - In IDLE with start_i, hold_i = 0 and flush_i = 0: write hi_o or lo_o from a_i at the edge.
  - No stall is raised and no state change occurs.
- flush_i:
  - In any state, the next state is IDLE and no HI/LO write happens in that cycle.
  - Takes priority over start_i, DONE completion and MTHI/MTLO.
- stall_o = (IDLE & start_i & op is mult/div & !flush_i) | CALC. It is low in DONE.

## Timing
- Iterative op (MUL_SINGLE=0, or any divide):
  - stall_o is high for WIDTH+1 cycles: the start cycle plus WIDTH CALC cycles.
  - DONE follows and lasts one cycle when hold_i = 0.
  - HI/LO are updated at the end of DONE.
  - The next instruction in E sees the new values combinationally.
- Single-cycle multiply: stall for 1 cycle, DONE in the next cycle, HI/LO written at its end.
- MTHI/MTLO: visible on hi_o/lo_o in the cycle after issue.
- rst mid-operation: immediate return to IDLE; HI/LO are cleared to 0.
- busy_o rises the cycle after acceptance and falls the cycle after DONE exits or after a flush.

## Structure
- Shared package mdu_pkg holds:
  - Op encodings (MDU_MULT … MDU_MTLO).
  - The state enum (IDLE, CALC, DONE).
  - The WIDTH-derived counter width, $clog2(WIDTH+1).
- Sub-module mdu_iter holds the per-cycle shift-add/shift-subtract datapath, including its accumulator and remainder registers.
- mdu_hilo holds the FSM, sign handling, the stall logic and the HI/LO registers.

## Test plan
- WIDTH=32, MUL_SINGLE=0, MULT a=−3, b=5:
  - stall_o high for exactly 33 cycles.
  - Then HI=0xFFFFFFFF, LO=0xFFFFFFF1.
- DIV a=7, b=−2 → LO=0xFFFFFFFD, HI=0x00000001.
- DIVU a=0xFFFFFFFF, b=0x10 → LO=0x0FFFFFFF, HI=0x0000000F.
- DIV a=5, b=0 → HI=5, LO=0xFFFFFFFF after 33 stall cycles.
- DIVU in progress, flush_i pulsed at the 10th CALC cycle → stall_o low in the next cycle; HI/LO keep their prior values (set earlier by MTHI 0x1234 and MTLO 0x5678).
- hold_i high for 3 cycles in DONE:
  - Exactly one HI/LO write.
  - No restart while start_i stays asserted.
  - An MTHI issued with hold_i = 1 is not written.
- MUL_SINGLE=1, MULTU 0xFFFFFFFF×2:
  - 1 stall cycle.
  - HI=0x00000001, LO=0xFFFFFFFE.
- rst asserted mid-CALC → hi_o=lo_o=0, busy_o=0 immediately.
